// File: rtl/gzip_sched_pkg.sv
// gzip_sched_pkg: shared types, default sizes and item-size legality check for the GZIP stream scheduler.
//   Exports state_e (scheduler FSM states), src_e (granted source),
//   DEF_DATA_W / DEF_SIZE_W / DEF_MAX_SIZE defaults and size_ok().
package gzip_sched_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SIZE_W   = 6;
    localparam int DEF_MAX_SIZE = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_ALIGN,
        S_TRL,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HDR,
        SRC_BLK,
        SRC_TRL
    } src_e;

    // An item is legal when it carries between 1 and max_size bits.
    function automatic logic size_ok(input int size, input int max_size);
        return size != 0 && size <= max_size;
    endfunction

endpackage

// File: rtl/gzip_stream_sched_if.sv
// gzip_stream_sched_if: item buses between the three GZIP producers, the scheduler and word_merge.
//   hdr_* / blk_* / trl_* : valid, last, size (bit count), data (LSB-aligned), ready
//   wm_*                  : valid, last, size, data towards word_merge
//   master : scheduler side (consumes producer items, drives readys and wm_*)
//   slave  : producer / word_merge side
interface gzip_stream_sched_if
    import gzip_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SIZE_W = DEF_SIZE_W
);

    logic              hdr_valid, hdr_last, hdr_ready;
    logic [SIZE_W-1:0] hdr_size;
    logic [DATA_W-1:0] hdr_data;

    logic              blk_valid, blk_last, blk_ready;
    logic [SIZE_W-1:0] blk_size;
    logic [DATA_W-1:0] blk_data;

    logic              trl_valid, trl_last, trl_ready;
    logic [SIZE_W-1:0] trl_size;
    logic [DATA_W-1:0] trl_data;

    logic              wm_valid, wm_last;
    logic [SIZE_W-1:0] wm_size;
    logic [DATA_W-1:0] wm_data;

    modport master (
        input  hdr_valid, hdr_last, hdr_size, hdr_data,
        input  blk_valid, blk_last, blk_size, blk_data,
        input  trl_valid, trl_last, trl_size, trl_data,
        output hdr_ready, blk_ready, trl_ready,
        output wm_valid, wm_last, wm_size, wm_data
    );

    modport slave (
        output hdr_valid, hdr_last, hdr_size, hdr_data,
        output blk_valid, blk_last, blk_size, blk_data,
        output trl_valid, trl_last, trl_size, trl_data,
        input  hdr_ready, blk_ready, trl_ready,
        input  wm_valid, wm_last, wm_size, wm_data
    );

endinterface

// File: rtl/gzip_sched_mux.sv
// gzip_sched_mux: registered 3:1 item mux with zero-pad injection and upper-bit masking.
//   clock, rst_n  : clock, asynchronous active-low reset
//   state_i       : scheduler state, selects the granted source
//   pad_i         : emit a zero padding item of pad_size_i bits this cycle
//   bus           : producer item inputs and registered wm_* outputs
//   acc_o         : granted source handed over an item this cycle
//   last_o        : that item is flagged last
//   legal_o       : that item has a legal size
//   size_o        : that item's size
module gzip_sched_mux
    import gzip_sched_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SIZE_W   = DEF_SIZE_W,
    parameter int MAX_SIZE = DEF_MAX_SIZE
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  state_e                state_i,
    input  logic                  pad_i,
    input  logic [SIZE_W-1:0]     pad_size_i,
    gzip_stream_sched_if.master   bus,
    output logic                  acc_o,
    output logic                  last_o,
    output logic                  legal_o,
    output logic [SIZE_W-1:0]     size_o
);

    src_e              sel;
    logic              v, l, ok;
    logic [SIZE_W-1:0] s;
    logic [DATA_W-1:0] d, mask;
    logic              wm_valid_d, wm_valid_q, wm_last_d, wm_last_q;
    logic [SIZE_W-1:0] wm_size_d, wm_size_q;
    logic [DATA_W-1:0] wm_data_d, wm_data_q;

    // Only the granted source is looked at, so a valid from any other source has no effect.
    always_comb begin
        sel = state_i == S_HDR ? SRC_HDR : state_i == S_BODY ? SRC_BLK : state_i == S_TRL ? SRC_TRL : SRC_NONE;
        v = sel == SRC_HDR ? bus.hdr_valid : sel == SRC_BLK ? bus.blk_valid : sel == SRC_TRL ? bus.trl_valid : 1'b0;
        l = sel == SRC_HDR ? bus.hdr_last : sel == SRC_BLK ? bus.blk_last : sel == SRC_TRL ? bus.trl_last : 1'b0;
        s = sel == SRC_HDR ? bus.hdr_size : sel == SRC_BLK ? bus.blk_size : sel == SRC_TRL ? bus.trl_size : '0;
        d = sel == SRC_HDR ? bus.hdr_data : sel == SRC_BLK ? bus.blk_data : sel == SRC_TRL ? bus.trl_data : '0;
        mask = int'(s) >= DATA_W ? '1 : ~({DATA_W{1'b1}} << s);
        ok = v && size_ok(int'(s), MAX_SIZE);
        acc_o = v;
        last_o = l;
        legal_o = size_ok(int'(s), MAX_SIZE);
        size_o = s;
        wm_valid_d = ok || pad_i;
        wm_last_d = ok && l && sel == SRC_TRL;
        wm_size_d = pad_i ? pad_size_i : ok ? s : '0;
        wm_data_d = ok ? d & mask : '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wm_valid_q <= 1'b0;
            wm_last_q  <= 1'b0;
            wm_size_q  <= '0;
            wm_data_q  <= '0;
        end else begin
            wm_valid_q <= wm_valid_d;
            wm_last_q  <= wm_last_d;
            wm_size_q  <= wm_size_d;
            wm_data_q  <= wm_data_d;
        end
    end

    assign bus.wm_valid = wm_valid_q;
    assign bus.wm_last  = wm_last_q;
    assign bus.wm_size  = wm_size_q;
    assign bus.wm_data  = wm_data_q;

endmodule

// File: rtl/gzip_stream_sched.sv
// gzip_stream_sched: sequences header, deflate body and trailer items of a GZIP member into word_merge,
//   padding with zeros so the trailer starts byte-aligned.
//   clock, rst_n : clock, asynchronous active-low reset
//   start_i      : begin a new member (honoured in IDLE/DONE only)
//   bus          : producer items in (hdr/blk/trl), readys out, wm_* item out
//   busy_o       : member in progress
//   done_o       : member complete
//   err_o        : sticky illegal-size flag, cleared by an honoured start
//   Optional (GZIP_SCHED_STATS_EN): hdr_bits_o, blk_bits_o, trl_bits_o = legal bits emitted per source.
module gzip_stream_sched
    import gzip_sched_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SIZE_W   = DEF_SIZE_W,
    parameter int MAX_SIZE = DEF_MAX_SIZE
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start_i,
    gzip_stream_sched_if.master bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
`ifdef GZIP_SCHED_STATS_EN
    ,
    output logic [31:0]         hdr_bits_o,
    output logic [31:0]         blk_bits_o,
    output logic [31:0]         trl_bits_o
`endif
);

    state_e            state_d, state_q;
    logic [2:0]        bit_pos_d, bit_pos_q;
    logic              err_d, err_q;
    logic              start_ok, pad, acc, last, legal;
    logic [SIZE_W-1:0] size, pad_size;
    logic [2:0]        emit3;

    gzip_sched_mux #(
        .DATA_W   (DATA_W),
        .SIZE_W   (SIZE_W),
        .MAX_SIZE (MAX_SIZE)
    ) u_mux (
        .clock      (clock),
        .rst_n      (rst_n),
        .state_i    (state_q),
        .pad_i      (pad),
        .pad_size_i (pad_size),
        .bus        (bus),
        .acc_o      (acc),
        .last_o     (last),
        .legal_o    (legal),
        .size_o     (size)
    );

    // Readys are Moore outputs of the state alone.
    assign bus.hdr_ready = state_q == S_HDR;
    assign bus.blk_ready = state_q == S_BODY;
    assign bus.trl_ready = state_q == S_TRL;
    assign busy_o        = state_q != S_IDLE && state_q != S_DONE;
    assign done_o        = state_q == S_DONE;
    assign err_o         = err_q;

    assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign pad      = state_q == S_ALIGN && bit_pos_q != 3'd0;
    assign pad_size = SIZE_W'(4'd8 - {1'b0, bit_pos_q});
    // Padding of 8-bit_pos bits brings bit_pos back to 0 modulo 8.
    assign emit3    = pad ? pad_size[2:0] : size[2:0];

    always_comb begin
        state_d   = state_q;
        bit_pos_d = bit_pos_q;
        err_d     = err_q;
        if (start_ok) begin
            state_d   = S_HDR;
            bit_pos_d = 3'd0;
            err_d     = 1'b0;
        end else begin
            if (pad || (acc && legal))
                bit_pos_d = bit_pos_q + emit3;
            if (acc && !legal)
                err_d = 1'b1;
            // A dropped last item still closes its phase.
            if (acc && last)
                state_d = state_q == S_HDR ? S_BODY : state_q == S_BODY ? S_ALIGN : S_DONE;
            if (state_q == S_ALIGN)
                state_d = S_TRL;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_pos_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_pos_q <= bit_pos_d;
            err_q     <= err_d;
        end
    end

`ifdef GZIP_SCHED_STATS_EN
    logic [31:0] hdr_bits_d, hdr_bits_q, blk_bits_d, blk_bits_q, trl_bits_d, trl_bits_q;

    // Padding is never counted: it is only emitted in ALIGN, where no source is granted.
    always_comb begin
        hdr_bits_d = hdr_bits_q;
        blk_bits_d = blk_bits_q;
        trl_bits_d = trl_bits_q;
        if (start_ok) begin
            hdr_bits_d = '0;
            blk_bits_d = '0;
            trl_bits_d = '0;
        end else if (acc && legal) begin
            hdr_bits_d = state_q == S_HDR ? hdr_bits_q + 32'(size) : hdr_bits_q;
            blk_bits_d = state_q == S_BODY ? blk_bits_q + 32'(size) : blk_bits_q;
            trl_bits_d = state_q == S_TRL ? trl_bits_q + 32'(size) : trl_bits_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hdr_bits_q <= '0;
            blk_bits_q <= '0;
            trl_bits_q <= '0;
        end else begin
            hdr_bits_q <= hdr_bits_d;
            blk_bits_q <= blk_bits_d;
            trl_bits_q <= trl_bits_d;
        end
    end

    assign hdr_bits_o = hdr_bits_q;
    assign blk_bits_o = blk_bits_q;
    assign trl_bits_o = trl_bits_q;
`endif

endmodule

// File: tb/tb_gzip_stream_sched.sv
// tb_gzip_stream_sched: directed self-checking bench for gzip_stream_sched.
//   Covers reset, nominal member, aligned body, illegal sizes, trailer contention,
//   ignored start while busy, asynchronous reset mid-body and restart.
module tb_gzip_stream_sched;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;
    int   checks = 0;
    int   errors = 0;

`ifdef GZIP_SCHED_STATS_EN
    logic [31:0] hdr_bits, blk_bits, trl_bits;
`endif

    gzip_stream_sched_if bus ();

    gzip_stream_sched dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .start_i (start),
        .bus     (bus),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
`ifdef GZIP_SCHED_STATS_EN
        ,
        .hdr_bits_o (hdr_bits),
        .blk_bits_o (blk_bits),
        .trl_bits_o (trl_bits)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wm(input string tag, input logic v, input logic l, input logic [5:0] s, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(bus.wm_valid), 64'(v));
        chk({tag, "_last"}, 64'(bus.wm_last), 64'(l));
        chk({tag, "_size"}, 64'(bus.wm_size), 64'(s));
        chk({tag, "_data"}, 64'(bus.wm_data), 64'(d));
    endtask

    task automatic put(input int src, input logic [31:0] d, input logic [5:0] s, input logic l);
        case (src)
            0: begin bus.hdr_valid = 1'b1; bus.hdr_data = d; bus.hdr_size = s; bus.hdr_last = l; end
            1: begin bus.blk_valid = 1'b1; bus.blk_data = d; bus.blk_size = s; bus.blk_last = l; end
            default: begin bus.trl_valid = 1'b1; bus.trl_data = d; bus.trl_size = s; bus.trl_last = l; end
        endcase
    endtask

    task automatic drop(input int src);
        case (src)
            0: bus.hdr_valid = 1'b0;
            1: bus.blk_valid = 1'b0;
            default: bus.trl_valid = 1'b0;
        endcase
    endtask

    // Present one item for one cycle, then check what word_merge sees the cycle after.
    task automatic item(input string tag, input int src, input logic [31:0] d, input logic [5:0] s, input logic l,
                        input logic ev, input logic el, input logic [5:0] es, input logic [31:0] ed);
        put(src, d, s, l);
        tick();
        drop(src);
        chk_wm(tag, ev, el, es, ed);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic nominal(input string p);
        do_start();
        chk({p, "_busy"}, 64'(busy), 64'd1);
        chk({p, "_rdy_hdr"}, 64'({bus.hdr_ready, bus.blk_ready, bus.trl_ready}), 64'b100);
        item({p, "_h0"}, 0, 32'h1F, 6'd8, 1'b0, 1'b1, 1'b0, 6'd8, 32'h1F);
        item({p, "_h1"}, 0, 32'h8B, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'h8B);
        chk({p, "_rdy_blk"}, 64'({bus.hdr_ready, bus.blk_ready, bus.trl_ready}), 64'b010);
        item({p, "_b0"}, 1, 32'h5, 6'd3, 1'b0, 1'b1, 1'b0, 6'd3, 32'h5);
        item({p, "_b1"}, 1, 32'h1, 6'd7, 1'b1, 1'b1, 1'b0, 6'd7, 32'h1);
        chk({p, "_rdy_align"}, 64'({bus.hdr_ready, bus.blk_ready, bus.trl_ready}), 64'b000);
        tick();
        chk_wm({p, "_pad"}, 1'b1, 1'b0, 6'd6, 32'h0);
        chk({p, "_rdy_trl"}, 64'({bus.hdr_ready, bus.blk_ready, bus.trl_ready}), 64'b001);
        item({p, "_t"}, 2, 32'hDEADBEEF, 6'd32, 1'b1, 1'b1, 1'b1, 6'd32, 32'hDEADBEEF);
        chk({p, "_done"}, 64'({done, busy, err}), 64'b100);
`ifdef GZIP_SCHED_STATS_EN
        chk({p, "_hdr_bits"}, 64'(hdr_bits), 64'd16);
        chk({p, "_blk_bits"}, 64'(blk_bits), 64'd10);
        chk({p, "_trl_bits"}, 64'(trl_bits), 64'd32);
`endif
        tick();
        chk({p, "_idle_out"}, 64'(bus.wm_valid), 64'd0);
    endtask

    initial begin
        bus.hdr_valid = 1'b0; bus.hdr_last = 1'b0; bus.hdr_size = '0; bus.hdr_data = '0;
        bus.blk_valid = 1'b0; bus.blk_last = 1'b0; bus.blk_size = '0; bus.blk_data = '0;
        bus.trl_valid = 1'b0; bus.trl_last = 1'b0; bus.trl_size = '0; bus.trl_data = '0;
        tick();
        tick();
        chk_wm("rst", 1'b0, 1'b0, 6'd0, 32'h0);
        chk("rst_flags", 64'({busy, done, err}), 64'b000);
        chk("rst_rdy", 64'({bus.hdr_ready, bus.blk_ready, bus.trl_ready}), 64'b000);
        rst_n = 1'b1;
        tick();
        nominal("nom");
        do_start();
        item("al_h", 0, 32'h1F, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'h1F);
        item("al_b", 1, 32'h3, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'h3);
        tick();
        chk("al_nopad", 64'(bus.wm_valid), 64'd0);
        item("al_t", 2, 32'hCAFEF00D, 6'd32, 1'b1, 1'b1, 1'b1, 6'd32, 32'hCAFEF00D);
        chk("al_done", 64'(done), 64'd1);
        do_start();
        item("il_h", 0, 32'hAA, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'hAA);
        item("il_b0", 1, 32'h7, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        chk("il_err0", 64'(err), 64'd1);
        item("il_b33", 1, 32'h7, 6'd33, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        item("il_mask", 1, 32'hFFFFFFF3, 6'd4, 1'b1, 1'b1, 1'b0, 6'd4, 32'h3);
        tick();
        chk_wm("il_pad", 1'b1, 1'b0, 6'd4, 32'h0);
        item("il_t40", 2, 32'h55, 6'd40, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
        chk("il_end", 64'({done, err}), 64'b11);
        put(2, 32'h1234, 6'd16, 1'b1);
        do_start();
        chk("ct_err_clr", 64'(err), 64'd0);
        chk("ct_rdy_hdr", 64'(bus.trl_ready), 64'd0);
        item("ct_h", 0, 32'h1F, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'h1F);
        item("ct_b", 1, 32'h2, 6'd2, 1'b1, 1'b1, 1'b0, 6'd2, 32'h2);
        chk("ct_rdy_align", 64'(bus.trl_ready), 64'd0);
        tick();
        chk_wm("ct_pad", 1'b1, 1'b0, 6'd6, 32'h0);
        chk("ct_rdy_trl", 64'(bus.trl_ready), 64'd1);
        tick();
        drop(2);
        chk_wm("ct_t", 1'b1, 1'b1, 6'd16, 32'h1234);
        chk("ct_done", 64'(done), 64'd1);
        do_start();
        item("rs_h", 0, 32'h1F, 6'd8, 1'b1, 1'b1, 1'b0, 6'd8, 32'h1F);
        do_start();
        chk("rs_ignored", 64'({busy, done, bus.blk_ready}), 64'b101);
        item("rs_b", 1, 32'h7, 6'd3, 1'b0, 1'b1, 1'b0, 6'd3, 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_wm("rs_async", 1'b0, 1'b0, 6'd0, 32'h0);
        chk("rs_async_flags", 64'({busy, done, err, bus.blk_ready}), 64'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        nominal("fresh");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gzip_stream_sched.md
Name: gzip_stream_sched

Overview:
Sequences the three producers of a GZIP member into the single word_merge bit packer: header source, deflate body source, then trailer source (CRC32/ISIZE).
- Grants exactly one source at a time through valid/ready handshakes.
- Tracks the bit position modulo 8 and inserts zero padding so the trailer starts byte-aligned.
- Drives in_last to word_merge on the final trailer item.

Parameters:
DATA_W, 32, width of data bus to/from sources and word_merge
SIZE_W, 6, width of size fields
MAX_SIZE, 32, largest legal item size in bits

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a new member (honoured in IDLE/DONE only)
hdr_valid/hdr_last  in  1/1  header item valid / final header item
hdr_size/hdr_data  in  SIZE_W/DATA_W  header item bit count / LSB-aligned bits
hdr_ready  out  1  header item accepted this cycle when valid
blk_valid/blk_last/blk_size/blk_data/blk_ready  same as hdr_*, deflate body source
trl_valid/trl_last/trl_size/trl_data/trl_ready  same as hdr_*, trailer source
wm_valid  out  1  to word_merge in_valid
wm_last  out  1  to word_merge in_last
wm_size  out  SIZE_W  to word_merge in_size
wm_data  out  DATA_W  to word_merge in_data
busy  out  1  state not IDLE/DONE
done  out  1  high in DONE
err  out  1  sticky illegal-size flag, cleared by start

Behaviour:
- Reset: state=IDLE, bit_pos=0. wm_valid, wm_last, wm_size, wm_data, err, done, all *_ready are 0.
- States and transitions:
  - IDLE: start -> HDR.
  - HDR: hdr_ready=1; accepted hdr_last -> BODY.
  - BODY: blk_ready=1; accepted blk_last -> ALIGN.
  - ALIGN: no ready asserted; one cycle only. If bit_pos!=0, emit zero-data item of size 8-bit_pos. Always -> TRL.
  - TRL: trl_ready=1; accepted trl_last -> DONE.
  - DONE: done=1; start -> HDR.
- Ready depends only on state (Moore), never on valid.
- Handshake: accept = valid & ready. Accepting the last item moves state the next cycle, so ready drops the cycle after the last accept.
- Output timing: accepted item appears on wm_* exactly 1 cycle later (registered) with wm_valid=1 for one cycle. wm_data bits above wm_size are forced to 0.
- No backpressure from word_merge: one item per cycle sustained.
- wm_last=1 only together with the item from the accepted trl_last.
- bit_pos (3 bits) += size mod 8 on every emitted item, including padding. Cleared to 0 on start.
- Illegal size (0 or >MAX_SIZE) on an accepted item: item dropped (no wm_valid), err set. If it carries *_last, the state transition still occurs. An illegal trl_last produces no wm_last.
- start while busy: ignored.
- start in DONE restarts: bit_pos=0, err=0, -> HDR.
- Source asserting valid while not granted: held off (ready=0), no effect.
- Reset mid-member: asynchronous return to IDLE. The same rst_n (inverted) resets word_merge, so no partial word survives.

Optional Feature:
GZIP_SCHED_STATS_EN
- Defined: adds outputs hdr_bits, blk_bits, trl_bits (each 32 bits, wrap-around). Each sums legal emitted sizes of its source; padding is not counted. All three clear on start and reset.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Package gzip_sched_pkg: state enum (IDLE, HDR, BODY, ALIGN, TRL, DONE), source-select enum, DATA_W/SIZE_W/MAX_SIZE constants, size-legality function.
- One sub-module: gzip_sched_mux. Registered 3:1 item mux plus zero-pad injection and upper-bit masking, selected by state.
- The FSM and bit_pos stay in the top.

Test Plan:
- Nominal member, start; header 0x1F/8, 0x8B/8(last); body 0x5/3, 0x1/7(last); trailer 0xDEADBEEF/32(last):
  - wm items in order, each 1 cycle after accept.
  - Pad item 0x0/6 (bit_pos=2).
  - wm_last only on 0xDEADBEEF.
  - done=1.
- Already aligned: header 8 bits, body 0x3/8(last) -> ALIGN emits no item; trailer follows directly.
- Illegal size: blk size 0 then size 33 -> no wm_valid for either, err=1; next start clears err.
- Source contention: trl_valid held high during HDR/BODY -> trl_ready=0, no wm output until TRL; then accepted 1 cycle after ALIGN.
- Restart and ignore: start pulse in BODY ignored. Reset asserted mid-BODY -> all outputs 0 asynchronously, state IDLE; fresh member completes correctly.
- With GZIP_SCHED_STATS_EN, nominal member -> hdr_bits=16, blk_bits=10, trl_bits=32.
